// File: rtl/alu_cmd_queue.sv
// rtl/alu_cmd_queue.sv - command FIFO feeding a single-outstanding ALU, response held until consumed.
// Optional ALU_TIMEOUT_EN: abort a WAIT that exceeds TIMEOUT cycles with a zero timeout response.
module alu_cmd_queue #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [3:0]               cmd_a,
  input  logic [3:0]               cmd_b,
  input  logic [1:0]               cmd_op,
  output logic [3:0]               alu_operandA,
  output logic [3:0]               alu_operandB,
  output logic [1:0]               alu_op,
  output logic                     alu_start,
  input  logic [3:0]               alu_result,
  input  logic                     alu_done,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [3:0]               rsp_result,
  output logic                     rsp_timeout,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT < 1) begin : g_bad_params
    $error("alu_cmd_queue: DEPTH must be a power of two >= 2 and TIMEOUT >= 1");
  end

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  state_t state, state_next;

  logic [9:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          push, pop;
  logic          load_ops, capture;

  assign cmd_ready = (level != LW'(DEPTH));
  assign push      = cmd_valid && cmd_ready;
  assign pop       = (state == ISSUE);
  assign alu_start = (state == ISSUE);
  assign rsp_valid = (state == RESP);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {cmd_a, cmd_b, cmd_op};
  end

`ifdef ALU_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] tcnt;
  logic          timed_out;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)               tcnt <= '0;
    else if (state == ISSUE) tcnt <= '0;
    else if (state == WAIT)  tcnt <= tcnt + TW'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)          rsp_timeout <= 1'b0;
    else if (capture)   rsp_timeout <= 1'b0;
    else if (timed_out) rsp_timeout <= 1'b1;
  end
`else
  assign rsp_timeout = 1'b0;
`endif

  always_comb begin
    state_next = state;
    load_ops   = 1'b0;
    capture    = 1'b0;
`ifdef ALU_TIMEOUT_EN
    timed_out  = 1'b0;
`endif
    case (state)
      IDLE: if (level != '0) begin
        state_next = ISSUE;
        load_ops   = 1'b1;
      end
      ISSUE: state_next = WAIT;
      // A done on the last allowed WAIT cycle still wins over the abort.
      WAIT: if (alu_done) begin
        state_next = RESP;
        capture    = 1'b1;
      end
`ifdef ALU_TIMEOUT_EN
      else if (tcnt == TW'(TIMEOUT - 1)) begin
        state_next = RESP;
        timed_out  = 1'b1;
      end
`endif
      RESP: if (rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      level        <= '0;
      alu_operandA <= '0;
      alu_operandB <= '0;
      alu_op       <= '0;
      rsp_result   <= '0;
    end else begin
      state <= state_next;
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
      // Operands are loaded on entry to ISSUE so they are valid alongside alu_start.
      if (load_ops) {alu_operandA, alu_operandB, alu_op} <= mem[rd_ptr];
      if (capture)  rsp_result <= alu_result;
`ifdef ALU_TIMEOUT_EN
      if (timed_out) rsp_result <= '0;
`endif
    end
  end
endmodule

// File: tb/tb_alu_cmd_queue.sv
// tb/tb_alu_cmd_queue.sv - scoreboard bench for alu_cmd_queue with a stub ALU and random traffic.
module tb_alu_cmd_queue;
  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 16;

  logic clk = 0;
  logic rst = 1;
  logic cmd_valid = 0, cmd_ready;
  logic [3:0] cmd_a = 0, cmd_b = 0;
  logic [1:0] cmd_op = 0;
  logic [3:0] alu_operandA, alu_operandB;
  logic [1:0] alu_op;
  logic alu_start, alu_done, rsp_valid, rsp_timeout;
  logic [3:0] alu_result, rsp_result;
  logic rsp_ready = 0;
  logic [$clog2(DEPTH):0] level;

  logic alu_done_m = 0, spur_done = 0;
  logic [3:0] alu_res_m = 0, spur_res = 0;
  assign alu_done   = alu_done_m | spur_done;
  assign alu_result = spur_done ? spur_res : alu_res_m;

  alu_cmd_queue #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op),
    .alu_operandA(alu_operandA), .alu_operandB(alu_operandB), .alu_op(alu_op),
    .alu_start(alu_start), .alu_result(alu_result), .alu_done(alu_done),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_timeout(rsp_timeout), .level(level)
  );

  always #5 clk = ~clk;

  int n_checks = 0, n_pass = 0;
  task automatic chk(input bit ok, input string name, input int act, input int exp);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  function automatic logic [3:0] ref_alu(input logic [3:0] a, input logic [3:0] b, input logic [1:0] op);
    case (op)
      2'd0:    return a + b;
      2'd1:    return a - b;
      2'd2:    return a & b;
      default: return a ^ b;
    endcase
  endfunction

  logic [9:0] exp_issue[$];
  logic [4:0] exp_rsp[$];
  int  model_lvl = 0, start_count = 0, rsp_count = 0;
  bit  outstanding = 0, prev_start = 0, prev_hs = 0;

  // Monitor: checks every issue and response against the scoreboard queues.
  always @(negedge clk) begin
    logic [9:0] e;
    logic [4:0] r;
    int acc;
    if (rst) begin
      exp_issue.delete(); exp_rsp.delete();
      model_lvl = 0; outstanding = 0; prev_start = 0; prev_hs = 0;
    end else begin
      chk(int'(level) == model_lvl, "level", level, model_lvl);
      chk(cmd_ready == (model_lvl != DEPTH), "cmd_ready", cmd_ready, model_lvl != DEPTH);
      chk(level <= DEPTH, "level_max", level, DEPTH);
      if (prev_hs) chk(!rsp_valid, "rsp_valid_fall", rsp_valid, 0);
      if (alu_start) begin
        chk(!prev_start, "start_one_cycle", 1, 0);
        chk(!outstanding, "one_outstanding", 1, 0);
        if (exp_issue.size() == 0) chk(0, "issue_unexpected", {alu_operandA, alu_operandB, alu_op}, -1);
        else begin
          e = exp_issue.pop_front();
          chk({alu_operandA, alu_operandB, alu_op} == e, "issue_order", {alu_operandA, alu_operandB, alu_op}, e);
        end
        outstanding = 1;
        start_count++;
      end
      prev_hs = 0;
      if (rsp_valid) begin
        if (exp_rsp.size() == 0) chk(0, "rsp_unexpected", rsp_result, -1);
        else if (rsp_ready) begin
          r = exp_rsp.pop_front();
          chk({rsp_timeout, rsp_result} == r, "rsp_data", {rsp_timeout, rsp_result}, r);
          outstanding = 0;
          rsp_count++;
          prev_hs = 1;
        end
      end
      acc = (cmd_valid && cmd_ready) ? 1 : 0;
      if (acc != 0) exp_issue.push_back({cmd_a, cmd_b, cmd_op});
      model_lvl = model_lvl + acc - (alu_start ? 1 : 0);
      prev_start = alu_start;
    end
  end

  // Stub ALU: answers each start after a latency, or stays silent.
  bit alu_silent = 0;
  int fixed_lat = 2, lat;
  logic [3:0] res;
  always begin
    @(negedge clk);
    if (!rst && alu_start) begin
      if (!alu_silent) begin
        res = ref_alu(alu_operandA, alu_operandB, alu_op);
        lat = (fixed_lat != 0) ? fixed_lat : int'($urandom_range(1, 4));
        repeat (lat) @(posedge clk);
        #1;
        alu_res_m = res; alu_done_m = 1; exp_rsp.push_back({1'b0, res});
        @(posedge clk); #1;
        alu_done_m = 0; alu_res_m = 4'($urandom);
      end else begin
`ifdef ALU_TIMEOUT_EN
        exp_rsp.push_back(5'h10);
`endif
      end
    end
  end

  bit rand_ready = 0, ready_fixed = 1;
  always @(posedge clk) begin
    #1;
    rsp_ready = rand_ready ? 1'($urandom_range(0, 1)) : ready_fixed;
  end

  task automatic cycle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic push_cmd(input logic [3:0] a, input logic [3:0] b, input logic [1:0] op);
    int n = 0;
    bit ok = 0;
    cmd_a = a; cmd_b = b; cmd_op = op; cmd_valid = 1;
    while (!ok && n < 200) begin
      @(negedge clk);
      ok = cmd_ready;
      @(posedge clk); #1;
      n++;
    end
    cmd_valid = 0;
    if (!ok) chk(0, "push_timeout", n, 200);
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((exp_issue.size() != 0 || exp_rsp.size() != 0 || outstanding) && n < budget) begin
      cycle(1); n++;
    end
    cycle(2);
    chk(n < budget, "drain", n, budget);
  endtask

  task automatic wait_rsp_valid(input string name);
    int n = 0;
    while (!rsp_valid && n < 100) begin cycle(1); n++; end
    chk(rsp_valid, name, rsp_valid, 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk(alu_start == 0, {tag, "_alu_start"}, alu_start, 0);
    chk(rsp_valid == 0, {tag, "_rsp_valid"}, rsp_valid, 0);
    chk(level == 0, {tag, "_level"}, level, 0);
    chk(cmd_ready == 1, {tag, "_cmd_ready"}, cmd_ready, 1);
    chk({alu_operandA, alu_operandB, alu_op} == 0, {tag, "_operands"}, {alu_operandA, alu_operandB, alu_op}, 0);
    chk(rsp_result == 0, {tag, "_rsp_result"}, rsp_result, 0);
    chk(rsp_timeout == 0, {tag, "_rsp_timeout"}, rsp_timeout, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int s0, r0;
    #2;
    check_reset_outputs("reset");
    cycle(2);
    rst = 0;
    cycle(1);

    // Single command: 3 + 5 with a two-cycle ALU.
    s0 = start_count;
    fixed_lat = 2; ready_fixed = 1;
    push_cmd(4'd3, 4'd5, 2'd0);
    wait_rsp_valid("single_rsp_valid");
    chk(rsp_result == 4'd8, "single_result", rsp_result, 8);
    chk(rsp_timeout == 0, "single_timeout", rsp_timeout, 0);
    drain(100);
    chk(start_count - s0 == 1, "single_start_count", start_count - s0, 1);

    // Spurious done while idle.
    spur_res = 4'hF; spur_done = 1; cycle(2); spur_done = 0; cycle(1);
    chk(rsp_result == 4'd8, "spur_idle_result", rsp_result, 8);
    chk(rsp_valid == 0, "spur_idle_valid", rsp_valid, 0);

    // Spurious done while a response is held.
    ready_fixed = 0; r0 = rsp_count;
    push_cmd(4'd7, 4'd12, 2'd2);
    wait_rsp_valid("spur_resp_valid");
    spur_done = 1; cycle(2); spur_done = 0;
    chk(rsp_result == 4'd4, "spur_resp_result", rsp_result, 4);
    chk(rsp_valid == 1, "spur_resp_held", rsp_valid, 1);
    ready_fixed = 1;
    drain(100);
    chk(rsp_valid == 0, "spur_resp_after", rsp_valid, 0);
    chk(rsp_count - r0 == 1, "spur_resp_count", rsp_count - r0, 1);

    // Ordering and pointer wrap under random back-pressure and ALU latency.
    s0 = start_count; r0 = rsp_count;
    rand_ready = 1; fixed_lat = 0;
    for (int i = 0; i < 10; i++) begin
      cycle($urandom_range(0, 2));
      push_cmd(4'($urandom), 4'($urandom), 2'($urandom));
    end
    drain(800);
    chk(start_count - s0 == 10, "order_starts", start_count - s0, 10);
    chk(rsp_count - r0 == 10, "order_rsps", rsp_count - r0, 10);
    rand_ready = 0; ready_fixed = 1;

    // Full FIFO: silent ALU, consumer stalled.
    alu_silent = 1; ready_fixed = 0;
    for (int i = 1; i <= 5; i++) push_cmd(4'(i), 4'(i + 8), 2'(i));
    cmd_a = 4'd6; cmd_b = 4'd14; cmd_op = 2'd2; cmd_valid = 1;
    cycle(5);
    chk(level == DEPTH, "full_level", level, DEPTH);
    chk(cmd_ready == 0, "full_cmd_ready", cmd_ready, 0);
    cmd_valid = 0;
    rst = 1; cycle(2); rst = 0; cycle(1);

    // Reset in WAIT with two commands queued.
    push_cmd(4'd9, 4'd3, 2'd1);
    push_cmd(4'd10, 4'd4, 2'd2);
    push_cmd(4'd11, 4'd5, 2'd3);
    cycle(2);
    chk(level == 2, "pre_reset_level", level, 2);
    rst = 1; #1;
    check_reset_outputs("midwait");
    cycle(1); rst = 0; cycle(1);
    spur_res = 4'hA; spur_done = 1; cycle(2); spur_done = 0;
    cycle(2);
    chk(rsp_valid == 0, "post_reset_valid", rsp_valid, 0);
    chk(rsp_result == 0, "post_reset_result", rsp_result, 0);
    chk(level == 0, "post_reset_level", level, 0);

    // Recovery after reset.
    alu_silent = 0; ready_fixed = 1; fixed_lat = 1;
    s0 = start_count;
    push_cmd(4'd9, 4'd4, 2'd1);
    drain(100);
    chk(start_count - s0 == 1, "recover_starts", start_count - s0, 1);

`ifdef ALU_TIMEOUT_EN
    begin
      int n = 0;
      alu_silent = 1;
      push_cmd(4'd2, 4'd2, 2'd0);
      while (!alu_start && n < 20) begin cycle(1); n++; end
      chk(alu_start, "to_start", alu_start, 1);
      n = 0;
      while (!rsp_valid && n < 40) begin cycle(1); n++; end
      chk(n == TIMEOUT + 1, "to_latency", n, TIMEOUT + 1);
      chk(rsp_result == 0, "to_result", rsp_result, 0);
      chk(rsp_timeout == 1, "to_flag", rsp_timeout, 1);
      drain(100);
      alu_silent = 0;
      push_cmd(4'd6, 4'd1, 2'd0);
      drain(100);
    end
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/alu_cmd_queue.md
ALU_CMD_QUEUE -- requirements
Module: alu_cmd_queue

Interface
REQ-001 Parameter DEPTH, default 4, command FIFO entries; power of two, at least 2.
REQ-002 Parameter TIMEOUT, default 16, cycles spent in WAIT before abort (used only with ALU_TIMEOUT_EN).
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 cmd_valid  input  1  upstream command present.
REQ-006 cmd_ready  output  1  FIFO can accept a command.
REQ-007 cmd_a  input  4  operand A.
REQ-008 cmd_b  input  4  operand B.
REQ-009 cmd_op  input  2  ALU opcode.
REQ-010 alu_operandA  output  4  operand A to ALU.
REQ-011 alu_operandB  output  4  operand B to ALU.
REQ-012 alu_op  output  2  opcode to ALU.
REQ-013 alu_start  output  1  one-cycle issue strobe to ALU.
REQ-014 alu_result  input  4  ALU result.
REQ-015 alu_done  input  1  ALU result valid.
REQ-016 rsp_valid  output  1  response held for the consumer.
REQ-017 rsp_ready  input  1  consumer accepts response.
REQ-018 rsp_result  output  4  captured ALU result.
REQ-019 rsp_timeout  output  1  response was produced by a timeout abort.
REQ-020 level  output  $clog2(DEPTH)+1  current FIFO occupancy.

Function
REQ-021 Push occurs on an edge where cmd_valid and cmd_ready are both 1; {cmd_a,cmd_b,cmd_op} is written at the write pointer.
REQ-022 cmd_ready = (level != DEPTH); it depends on occupancy only, so a pop in the same cycle does not enable a push into a full FIFO.
REQ-023 Read and write pointers wrap modulo DEPTH; level increments on push-only, decrements on pop-only, and is unchanged on push+pop.
REQ-024 FSM states: IDLE, ISSUE, WAIT, RESP.
REQ-025 IDLE -> ISSUE when level != 0; otherwise remain in IDLE.
REQ-026 ISSUE: alu_start=1 for exactly this cycle, alu_operandA/B/op driven from the FIFO head, the head is popped, next state is WAIT.
REQ-027 alu_operandA/B/op are registered at ISSUE and hold their value until the next ISSUE.
REQ-028 WAIT: on alu_done=1, alu_result is captured into rsp_result, rsp_timeout=0, next state is RESP.
REQ-029 RESP: rsp_valid=1; on rsp_ready=1 the FSM moves to IDLE and rsp_valid falls on the next cycle.
REQ-030 alu_done is ignored in IDLE, ISSUE and RESP.
REQ-031 Latency: a command pushed into an empty FIFO at edge N with the FSM in IDLE produces alu_start high in the cycle after edge N+1.
REQ-032 Commands issue strictly in FIFO order, with at most one outstanding at the ALU.

Reset
REQ-033 Reset asserted: FSM=IDLE, pointers=0, level=0, cmd_ready=1, alu_start=0, alu_operandA/B=0, alu_op=0, rsp_valid=0, rsp_result=0, rsp_timeout=0, timeout counter=0.
REQ-034 Reset asserted mid-operation discards all queued and in-flight commands; a later alu_done from the aborted command is ignored because the FSM is in IDLE.

Configuration
REQ-035 Macro ALU_TIMEOUT_EN defined: a counter clears on entry to WAIT and increments each WAIT cycle; if it reaches TIMEOUT without alu_done, the block enters RESP with rsp_result=0 and rsp_timeout=1.
REQ-036 alu_done in the same cycle as the counter reaching TIMEOUT takes priority and gives a normal response.
REQ-037 Macro ALU_TIMEOUT_EN undefined: no counter is built, WAIT lasts indefinitely, and rsp_timeout is tied to 0.

Verification
REQ-038 Single command: push A=3, B=5, op=0; ALU returns done with result 8 two cycles after start -> exactly one alu_start pulse with 3/5/0; then rsp_valid=1, rsp_result=8, rsp_timeout=0.
REQ-039 Full FIFO: rsp_ready=0 and alu_done never asserted, push 6 commands -> first command issues; cmd_ready drops when level=4; the sixth command is held; level never exceeds 4.
REQ-040 Ordering/wrap: stream 10 commands with random rsp_ready back-pressure -> alu_start operands appear in push order; pointers wrap; no command is lost or duplicated.
REQ-041 Spurious done: alu_done=1 while in IDLE and RESP -> rsp_result is unchanged and no extra rsp_valid appears.
REQ-042 Timeout (ALU_TIMEOUT_EN, TIMEOUT=16): withhold alu_done -> rsp_valid rises with rsp_result=0 and rsp_timeout=1 after 16 WAIT cycles; the next command issues normally.
REQ-043 Reset mid-WAIT with 2 commands queued -> all outputs take their reset values immediately; a following alu_done has no effect; level=0.
